// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: shared definitions for the datapath bus transfer controller.
// Holds the bus source/destination codes, the FSM state encoding, and a
// helper that identifies memory sources, which need extra read cycles.
package bus_xfer_pkg;

    localparam logic [4:0] SRC_R    = 5'd1;
    localparam logic [4:0] SRC_R1   = 5'd2;
    localparam logic [4:0] SRC_R2   = 5'd3;
    localparam logic [4:0] SRC_R3   = 5'd4;
    localparam logic [4:0] SRC_X    = 5'd5;
    localparam logic [4:0] SRC_Y    = 5'd6;
    localparam logic [4:0] SRC_Z    = 5'd7;
    localparam logic [4:0] SRC_STXY = 5'd8;
    localparam logic [4:0] SRC_STYZ = 5'd9;
    localparam logic [4:0] SRC_STXZ = 5'd10;
    localparam logic [4:0] SRC_AR   = 5'd11;
    localparam logic [4:0] SRC_IR   = 5'd12;
    localparam logic [4:0] SRC_PC   = 5'd13;
    localparam logic [4:0] SRC_AC   = 5'd14;
    localparam logic [4:0] SRC_IM   = 5'd15;
    localparam logic [4:0] SRC_DM   = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } xfer_state_e;

    // Codes arrive at whatever width the top is built with, so compare
    // on a 32-bit zero-extended value.
    function automatic logic is_mem_src(input logic [31:0] code);
        return (code == 32'(SRC_IM)) || (code == 32'(SRC_DM));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req     in  NREQ   request vector
//   ptr     in  IDX_W  highest-priority requester index for this search
//   gnt_oh  out NREQ   one-hot winner (all zero when no request)
//   gnt_idx out IDX_W  winner index
//   gnt_vld out 1      any request present
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        int unsigned pos;
        logic        found;
        pos     = 0;
        found   = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                gnt_oh[pos] = 1'b1;
                gnt_idx     = IDX_W'(pos);
            end
        end
        gnt_vld = |req;
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences register-to-register transfers over the shared
// datapath bus, arbitrating round-robin among NREQ requesters.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req/req_src/req_dst per-requester request level and packed codes
//   gnt, done           one-hot single-cycle accept / write-strobe pulses
//   read_en, write_en   bus source select / destination write code
//   busy                controller not idle
//   xfer_cnt, stall_cnt performance counters (only with BUS_XFER_CTRL_PERF_EN)
// All outputs come straight from flops; their next values are computed from
// the next state so they line up with the state register.
//
// state    | meaning
// ST_IDLE  | no transfer; arbitrate on any req
// ST_READ  | bus sourced from latched src; 1 + MEM_WAIT cycles for im/dm
// ST_WRITE | write strobe to latched dst; re-arbitrate for back-to-back
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SEL_W    = 5,
    parameter int MEM_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SEL_W-1:0] req_src,
    input  logic [NREQ*SEL_W-1:0] req_dst,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [SEL_W-1:0]      read_en,
    output logic [SEL_W-1:0]      write_en,
    output logic                  busy
`ifdef BUS_XFER_CTRL_PERF_EN
    ,
    output logic [15:0]           xfer_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WAIT_W = 2;

    xfer_state_e       state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [SEL_W-1:0]  dst_q, dst_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [SEL_W-1:0]  read_en_q, read_en_d;
    logic [SEL_W-1:0]  write_en_q, write_en_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    logic              accept;
    logic [SEL_W-1:0]  win_src;
    logic [SEL_W-1:0]  win_dst;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign win_src = req_src[int'(arb_idx)*SEL_W +: SEL_W];
    assign win_dst = req_dst[int'(arb_idx)*SEL_W +: SEL_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dst_d   = dst_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (arb_vld) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                    idx_d   = arb_idx;
                    src_d   = win_src;
                    dst_d   = win_dst;
                    ptr_d   = (int'(arb_idx) == NREQ-1) ? '0 : arb_idx + IDX_W'(1);
                    wait_d  = is_mem_src(32'(win_src)) ? WAIT_W'(MEM_WAIT) : '0;
                end else begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end
            end
            ST_READ: begin
                // Down-counter: leave READ at terminal count
                if (wait_q == '0) begin
                    state_d = ST_WRITE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic (next values of the output flops)
    always_comb begin
        gnt_d      = accept ? arb_oh : '0;
        done_d     = '0;
        write_en_d = '0;
        read_en_d  = (state_d != ST_IDLE) ? src_d : '0;
        busy_d     = (state_d != ST_IDLE);
        if (state_d == ST_WRITE) begin
            done_d[idx_q] = 1'b1;
            write_en_d    = dst_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= '0;
            done_q     <= '0;
            read_en_q  <= '0;
            write_en_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign read_en  = read_en_q;
    assign write_en = write_en_q;
    assign busy     = busy_q;

`ifdef BUS_XFER_CTRL_PERF_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A stall cycle: someone is asking but no request is accepted at this edge
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q + 16'(|done_q);
        stall_cnt_d = stall_cnt_q;
        if ((|req) && !accept && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
